rr_arb2_bh: RTL and testbench

RR_ARB2_BH -- requirements
Module: rr_arb2_bh

---
 rtl/rr_arb2_bh_pkg.sv | 22 ++
 rtl/rr_arb2_bh_hold_cnt.sv | 40 ++++
 rtl/rr_arb2_defs.vh | 12 +
 rtl/rr_arb2_bh.sv | 111 +++++++++++
 tb/tb_rr_arb2_bh.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb2_bh_pkg.sv
// Types and helpers shared by the round-robin arbiter and its hold counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arb2_bh_pkg;

`include "rr_arb2_defs.vh"

  // State codes double as the grant vector, so gnt_out is a plain decode.
  typedef enum logic [1:0] {
    ST_IDLE = `RR_ST_IDLE,
    ST_GNT0 = `RR_ST_GNT0,
    ST_GNT1 = `RR_ST_GNT1
  } state_t;

  localparam int HOLD_MAX_DEF = `RR_HOLD_MAX_DEF;

  // Map a requester index to its grant state.
  function automatic state_t gnt_state(input logic idx);
    return idx ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/rr_arb2_bh_hold_cnt.sv
// Counts consecutive cycles the current grant has been held.
// Latency: clr/en take effect on the next rising edge; clr wins over en.
// Backpressure: none; saturation is the caller's job (it drops en).
module hold_cnt
  import rr_arb2_bh_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on grant entry, otherwise step when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, asynchronously cleared by active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rr_arb2_defs.vh
// Shared encodings and defaults for the two-way round-robin arbiter.
// Pulled in by the RTL package and by the bench so both agree on state codes.
// Guarded so that multiple inclusion within one compilation unit is harmless.
`ifndef RR_ARB2_DEFS_VH
`define RR_ARB2_DEFS_VH

`define RR_ST_IDLE      2'b00
`define RR_ST_GNT0      2'b01
`define RR_ST_GNT1      2'b10
`define RR_HOLD_MAX_DEF 8

`endif

// File: rtl/rr_arb2_bh.sv
// Two-requester round-robin arbiter with a maximum hold time per grant.
// Latency: request sampled at an edge is granted right after that edge.
// Backpressure: a holder is force-revoked after HOLD_MAX cycles (tmo_out pulse).
module rr_arb2_bh
  import rr_arb2_bh_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_out,
  output logic       busy_out,
  output logic       tmo_out,
  output logic       owner_out
);

  // Count value seen during the last permitted cycle of a grant.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q;
  state_t           state_d;
  logic             ptr_q;
  logic             ptr_d;
  logic             owner_q;
  logic             owner_d;
  logic             tmo_q;
  logic             tmo_d;
  logic             cur;
  logic             expired;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             cnt_en;

  assign expired = (cnt == CNT_LAST);

  // Next-state, fairness pointer, owner and timeout-pulse computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    tmo_d   = 1'b0;
    cur     = (state_q == ST_GNT1);
    case (state_q)
      ST_IDLE: begin
        if (req_i == 2'b11) begin
          state_d = gnt_state(ptr_q);
        end else if (req_i[0]) begin
          state_d = ST_GNT0;
        end else if (req_i[1]) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        // A dropped request is always a normal release, even if the hold
        // budget runs out on the same edge; only a still-held request
        // at expiry counts as a forced release.
        if (!req_i[cur] || expired) begin
          state_d = req_i[~cur] ? gnt_state(~cur) : ST_IDLE;
          ptr_d   = ~cur;
          tmo_d   = req_i[cur];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if ((state_d != ST_IDLE) && (state_d != state_q)) begin
      owner_d = (state_d == ST_GNT1);
    end
  end

  // Restart the hold count on any grant entry (including handoff), and
  // park it at the last value rather than wrapping.
  assign cnt_clr = (state_d != state_q) || (state_d == ST_IDLE);
  assign cnt_en  = !cnt_clr && !expired;

  hold_cnt #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt)
  );

  // Arbiter state register; reset drops the grant without a clock edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs are straight decodes of registers; the illegal code 2'b11
  // decodes to no grant while it recovers to IDLE.
  assign gnt_out   = {state_q == ST_GNT1, state_q == ST_GNT0};
  assign busy_out  = (state_q == ST_GNT0) || (state_q == ST_GNT1);
  assign tmo_out   = tmo_q;
  assign owner_out = owner_q;

endmodule

// File: tb/tb_rr_arb2_bh.sv
// Bench for rr_arb2_bh: table of per-cycle vectors through a scoreboard queue,
// plus a hand-written asynchronous-reset sequence.
// Outputs are sampled 1 time unit after each rising edge.
module tb_rr_arb2_bh;

`include "rr_arb2_defs.vh"

  localparam int H = `RR_HOLD_MAX_DEF;

  typedef struct {
    string      sec;
    bit         rst_before;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       tmo;
    logic       own;
  } vec_t;

  typedef struct {
    string      tag;
    logic [1:0] gnt;
    logic       tmo;
    logic       own;
  } exp_t;

  logic       clk;
  logic       rst_i;
  logic [1:0] req_i;
  logic [1:0] gnt_out;
  logic       busy_out;
  logic       tmo_out;
  logic       owner_out;

  int n_cmp = 0;
  int n_err = 0;

  vec_t vecs[$];
  exp_t sb[$];

  rr_arb2_bh dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .gnt_out   (gnt_out),
    .busy_out  (busy_out),
    .tmo_out   (tmo_out),
    .owner_out (owner_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void add(input string sec, input bit rb, input logic [1:0] r,
                              input logic [1:0] g, input logic t, input logic o);
    vec_t v;
    v.sec = sec; v.rst_before = rb; v.req = r; v.gnt = g; v.tmo = t; v.own = o;
    vecs.push_back(v);
  endfunction

  function automatic void push_exp(input string tag, input logic [1:0] g,
                                   input logic t, input logic o);
    exp_t e;
    e.tag = tag; e.gnt = g; e.tmo = t; e.own = o;
    sb.push_back(e);
  endfunction

  task automatic sample_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, " gnt"},   {6'd0, gnt_out},   {6'd0, e.gnt});
      check({e.tag, " busy"},  {7'd0, busy_out},  {7'd0, |e.gnt});
      check({e.tag, " tmo"},   {7'd0, tmo_out},   {7'd0, e.tmo});
      check({e.tag, " owner"}, {7'd0, owner_out}, {7'd0, e.own});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    req_i = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    req_i = v.req;
    push_exp($sformatf("%s[%0d]", v.sec, idx), v.gnt, v.tmo, v.own);
    @(posedge clk);
    #1;
    sample_cmp();
  endtask

  initial begin
    rst_i = 1'b0;
    req_i = 2'b11;

    // Single requester: three cycles of grant, then idle.
    add("single", 1, 2'b01, 2'b01, 1'b0, 1'b0);
    add("single", 0, 2'b01, 2'b01, 1'b0, 1'b0);
    add("single", 0, 2'b01, 2'b01, 1'b0, 1'b0);
    add("single", 0, 2'b00, 2'b00, 1'b0, 1'b0);
    add("single", 0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Contention: HOLD_MAX cycles each, forced handoffs with tmo pulses.
    for (int i = 0; i < H; i++) add("contend", i == 0, 2'b11, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < H; i++) add("contend", 0, 2'b11, 2'b10, i == 0, 1'b1);
    add("contend", 0, 2'b11, 2'b01, 1'b1, 1'b0);
    add("contend", 0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Normal handoff with no idle cycle; owner held in IDLE.
    add("handoff", 1, 2'b01, 2'b01, 1'b0, 1'b0);
    add("handoff", 0, 2'b11, 2'b01, 1'b0, 1'b0);
    add("handoff", 0, 2'b10, 2'b10, 1'b0, 1'b1);
    add("handoff", 0, 2'b00, 2'b00, 1'b0, 1'b1);
    add("handoff", 0, 2'b00, 2'b00, 1'b0, 1'b1);

    // Expiry alone: 12 cycles of request -> 8 granted, 1 gap with tmo, regrant.
    for (int i = 0; i < 12; i++) begin
      if (i < H)       add("expiry", i == 0, 2'b01, 2'b01, 1'b0, 1'b0);
      else if (i == H) add("expiry", 0, 2'b01, 2'b00, 1'b1, 1'b0);
      else             add("expiry", 0, 2'b01, 2'b01, 1'b0, 1'b0);
    end
    add("expiry", 0, 2'b00, 2'b00, 1'b0, 1'b0);
    add("expiry", 0, 2'b11, 2'b10, 1'b0, 1'b1);
    add("expiry", 0, 2'b00, 2'b00, 1'b0, 1'b1);

    // Release on the same edge as expiry is a normal release.
    for (int i = 0; i < H; i++) add("coincide", i == 0, 2'b01, 2'b01, 1'b0, 1'b0);
    add("coincide", 0, 2'b00, 2'b00, 1'b0, 1'b0);
    add("coincide", 0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Pointer alternation and request toggling on the non-granted line.
    add("fair", 1, 2'b10, 2'b10, 1'b0, 1'b1);
    add("fair", 0, 2'b00, 2'b00, 1'b0, 1'b1);
    add("fair", 0, 2'b11, 2'b01, 1'b0, 1'b0);
    add("fair", 0, 2'b00, 2'b00, 1'b0, 1'b0);
    add("fair", 0, 2'b11, 2'b10, 1'b0, 1'b1);
    add("fair", 0, 2'b01, 2'b01, 1'b0, 1'b0);
    add("fair", 0, 2'b11, 2'b01, 1'b0, 1'b0);
    add("fair", 0, 2'b01, 2'b01, 1'b0, 1'b0);
    add("fair", 0, 2'b11, 2'b01, 1'b0, 1'b0);
    add("fair", 0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Reset dominates active requests across clock edges.
    repeat (2) @(posedge clk);
    #1;
    check("reset gnt",   {6'd0, gnt_out},   8'd0);
    check("reset busy",  {7'd0, busy_out},  8'd0);
    check("reset tmo",   {7'd0, tmo_out},   8'd0);
    check("reset owner", {7'd0, owner_out}, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      apply(vecs[i], i);
    end

    // Asynchronous reset in the middle of a GNT1 cycle.
    do_reset();
    add("async", 0, 2'b10, 2'b10, 1'b0, 1'b1);
    add("async", 0, 2'b10, 2'b10, 1'b0, 1'b1);
    apply(vecs[vecs.size()-2], vecs.size()-2);
    apply(vecs[vecs.size()-1], vecs.size()-1);
    #2;
    rst_i = 1'b0;
    #1;
    check("async mid gnt",   {6'd0, gnt_out},   8'd0);
    check("async mid busy",  {7'd0, busy_out},  8'd0);
    check("async mid owner", {7'd0, owner_out}, 8'd0);
    check("async mid tmo",   {7'd0, tmo_out},   8'd0);
    req_i = 2'b11;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("async release gnt", {6'd0, gnt_out}, 8'd0);
    push_exp("async first", 2'b01, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sample_cmp();
    add("async", 0, 2'b00, 2'b00, 1'b0, 1'b0);
    apply(vecs[vecs.size()-1], vecs.size()-1);

    check("scoreboard_drained", sb.size() == 0 ? 8'd1 : 8'd0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
